// File: rtl/axis_slave_fifo_pkg.sv
// rtl/axis_slave_fifo_pkg.sv - shared defaults and clog2 for the stream slave FIFO
// AXIS_PKT_COUNT_EN is left undefined by default; define it on the command line to enable packet mode.
package axis_slave_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - dual-port register array, synchronous write, asynchronous read
// The array has no reset; the top masks stale contents through valid_out.
module axis_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_slave_fifo.sv
// rtl/axis_slave_fifo.sv - AXI-stream slave with show-ahead FIFO and level/status outputs
// Optional packet counting and store-and-forward under AXIS_PKT_COUNT_EN.
module axis_slave_fifo
  import axis_slave_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              last,
  output logic              ready,
  input  logic              stop,
  output logic [DATA_W-1:0] data_out,
  output logic              last_out,
  output logic              valid_out,
  input  logic              read,
  output logic [CNT_W-1:0]  level,
  output logic              full,
`ifdef AXIS_PKT_COUNT_EN
  output logic [CNT_W-1:0]  pkt_count,
`endif
  output logic              empty
);

  localparam int AW = CNT_W - 1;

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [DATA_W:0]  head;

  // Extra pointer MSB lets the plain difference span 0..DEPTH.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == CNT_W'(DEPTH));
  assign empty = (level == '0);

  assign ready = reset_n & ~stop & ~full;
  assign push  = valid & ready;
  assign pop   = valid_out & read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
    end
  end

  axis_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({last, data}),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (head)
  );

`ifdef AXIS_PKT_COUNT_EN
  logic pkt_in;
  logic pkt_out;

  assign pkt_in  = push & last;
  assign pkt_out = pop & head[DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (pkt_in && !pkt_out) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end else if (pkt_out && !pkt_in) begin
      pkt_count <= pkt_count - CNT_W'(1);
    end
  end

  // The full term releases packets longer than DEPTH cut-through instead of deadlocking.
  assign valid_out = ~empty & ((pkt_count != '0) | full);
`else
  assign valid_out = ~empty;
`endif

  assign data_out = valid_out ? head[DATA_W-1:0] : '0;
  assign last_out = valid_out ? head[DATA_W] : 1'b0;

endmodule

// File: tb/tb_axis_slave_fifo.sv
// tb/tb_axis_slave_fifo.sv - self-checking bench for axis_slave_fifo (default build or AXIS_PKT_COUNT_EN)
module tb_axis_slave_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;
`ifdef AXIS_PKT_COUNT_EN
  localparam logic PKT = 1'b1;
`else
  localparam logic PKT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              last;
  logic              ready;
  logic              stop;
  logic [DATA_W-1:0] data_out;
  logic              last_out;
  logic              valid_out;
  logic              read;
  logic [CNT_W-1:0]  level;
  logic              full;
  logic              empty;
`ifdef AXIS_PKT_COUNT_EN
  logic [CNT_W-1:0]  pkt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       stop;
    logic       read;
    logic       exp_ready;
    logic       exp_vo;
    logic [7:0] exp_do;
    logic [4:0] exp_level;
  } vec_t;

  vec_t            tbl[$];
  logic [DATA_W:0] model_q[$];

  always #5 clk = ~clk;

  axis_slave_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data      (data),
    .valid     (valid),
    .last      (last),
    .ready     (ready),
    .stop      (stop),
    .data_out  (data_out),
    .last_out  (last_out),
    .valid_out (valid_out),
    .read      (read),
    .level     (level),
    .full      (full),
`ifdef AXIS_PKT_COUNT_EN
    .pkt_count (pkt_count),
`endif
    .empty     (empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0;
    data  = '0;
    last  = 1'b0;
    stop  = 1'b0;
    read  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'(0));
    check({tag, "_valid_out"}, 32'(valid_out), 32'(0));
    check({tag, "_data_out"}, 32'(data_out), 32'(0));
    check({tag, "_last_out"}, 32'(last_out), 32'(0));
    check({tag, "_level"}, 32'(level), 32'(0));
    check({tag, "_full"}, 32'(full), 32'(0));
    check({tag, "_empty"}, 32'(empty), 32'(1));
`ifdef AXIS_PKT_COUNT_EN
    check({tag, "_pkt_count"}, 32'(pkt_count), 32'(0));
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #2;
    check_reset_values("rst");
    step();
    step();
    reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic s, input logic r,
                              input logic er, input logic evo, input logic [7:0] edo,
                              input logic [4:0] elev);
    vec_t t;
    t.valid = v; t.data = d; t.stop = s; t.read = r;
    t.exp_ready = er; t.exp_vo = evo; t.exp_do = edo; t.exp_level = elev;
    return t;
  endfunction

  initial begin
    int sent;
    int got;
    int sz;
    int npk;
    logic exp_ready;
    logic exp_vo;
    logic [DATA_W:0] exp_head;

    // Streaming 1..8, a stop window holding 0xAA, then a full drain.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b1, 8'(k + 1), 1'b0, 1'b0, 1'b1, k > 0, (k > 0) ? 8'h01 : 8'h00, 5'(k)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5'd8));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 5'd8));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5'd8));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 5'd9));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'(k), 5'(10 - k)));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 5'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      valid = tbl[i].valid;
      data  = tbl[i].data;
      last  = PKT;
      stop  = tbl[i].stop;
      read  = tbl[i].read;
      #2;
      check($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_valid_out", i), 32'(valid_out), 32'(tbl[i].exp_vo));
      check($sformatf("tbl%0d_data_out", i), 32'(data_out), 32'(tbl[i].exp_do));
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      step();
    end

    // Fill to DEPTH, hold a 17th word, then a single pop.
    do_reset();
    valid = 1'b1;
    last  = PKT;
    for (int i = 0; i < DEPTH; i++) begin
      data = 8'(16 + i);
      step();
    end
    data = 8'hEE;
    #2;
    check("full_flag", 32'(full), 32'(1));
    check("full_ready", 32'(ready), 32'(0));
    check("full_level", 32'(level), 32'(16));
    step();
    #2;
    check("full_no17", 32'(level), 32'(16));
    check("full_head", 32'(data_out), 32'(8'h10));
    read = 1'b1;
    step();
    read = 1'b0;
    #2;
    check("pop_full_level", 32'(level), 32'(15));
    check("pop_full_ready", 32'(ready), 32'(1));
    check("pop_full_flag", 32'(full), 32'(0));
    check("pop_full_head", 32'(data_out), 32'(8'h11));
    step();
    valid = 1'b0;
    #2;
    check("refill_level", 32'(level), 32'(16));
    check("refill_full", 32'(full), 32'(1));

    // 100 words through at one per cycle, level pinned at 1.
    do_reset();
    valid = 1'b1;
    last  = PKT;
    read  = 1'b1;
    data  = 8'h00;
    step();
    for (int i = 1; i <= 100; i++) begin
      data = 8'(i);
      #2;
      check($sformatf("cont%0d_level", i), 32'(level), 32'(1));
      check($sformatf("cont%0d_data", i), 32'(data_out), 32'(8'(i - 1)));
      step();
    end
    valid = 1'b0;
    #2;
    check("cont_tail", 32'(data_out), 32'(100));
    step();
    read = 1'b0;
    #2;
    check("cont_empty", 32'(empty), 32'(1));

    // Mid-operation reset with 7 words held.
    do_reset();
    valid = 1'b1;
    last  = PKT;
    for (int i = 0; i < 7; i++) begin
      data = 8'(8'h60 + i);
      step();
    end
    valid = 1'b0;
    #2;
    check("pre_rst_level", 32'(level), 32'(7));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    read = 1'b1;
    step();
    check("midrst_read_nothing", 32'(valid_out), 32'(0));
    check("midrst_level_hold", 32'(level), 32'(0));
    reset_n = 1'b1;
    read  = 1'b0;
    valid = 1'b1;
    data  = 8'h5C;
    last  = PKT;
    step();
    valid = 1'b0;
    #2;
    check("post_rst_vo", 32'(valid_out), 32'(1));
    check("post_rst_data", 32'(data_out), 32'(8'h5C));
    check("post_rst_level", 32'(level), 32'(1));

`ifdef AXIS_PKT_COUNT_EN
    // Store-and-forward on a 3-word packet.
    do_reset();
    for (int w = 0; w < 3; w++) begin
      valid = 1'b1;
      data  = 8'(8'h30 + w);
      last  = (w == 2);
      #2;
      check($sformatf("pk3_pre%0d_vo", w), 32'(valid_out), 32'(0));
      step();
      valid = 1'b0;
      last  = 1'b0;
      #2;
      check($sformatf("pk3_post%0d_vo", w), 32'(valid_out), 32'(w == 2));
    end
    check("pk3_count", 32'(pkt_count), 32'(1));
    read = 1'b1;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("pk3_data%0d", w), 32'(data_out), 32'(8'(8'h30 + w)));
      check($sformatf("pk3_last%0d", w), 32'(last_out), 32'(w == 2));
      step();
      #2;
    end
    read = 1'b0;
    check("pk3_count_done", 32'(pkt_count), 32'(0));
    check("pk3_vo_done", 32'(valid_out), 32'(0));

    // A packet longer than DEPTH must drain cut-through.
    do_reset();
    sent = 0;
    got  = 0;
    read = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 20; cyc++) begin
      valid = (sent < 20);
      data  = 8'(8'h40 + sent);
      last  = (sent == 19);
      #2;
      if (valid_out) begin
        check($sformatf("pk20_data%0d", got), 32'(data_out), 32'(8'(8'h40 + got)));
        got++;
      end
      if (valid && ready) sent++;
      step();
    end
    idle_inputs();
    check("pk20_drained", 32'(got), 32'(20));
`endif

    // Random traffic against a queue model, alternating light and heavy read phases.
    do_reset();
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      valid = ($urandom_range(0, 99) < 70);
      data  = 8'($urandom);
      last  = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      read  = ((c / 80) % 2 == 0) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 85);
      #2;
      sz  = model_q.size();
      npk = 0;
      foreach (model_q[j]) if (model_q[j][DATA_W]) npk++;
      exp_ready = !stop && (sz < DEPTH);
      exp_vo    = (sz > 0) && (!PKT || npk > 0 || sz == DEPTH);
      exp_head  = exp_vo ? model_q[0] : '0;
      check($sformatf("rnd%0d_ready", c), 32'(ready), 32'(exp_ready));
      check($sformatf("rnd%0d_valid_out", c), 32'(valid_out), 32'(exp_vo));
      check($sformatf("rnd%0d_head", c), 32'({last_out, data_out}), 32'(exp_head));
      check($sformatf("rnd%0d_level", c), 32'(level), 32'(sz));
      check($sformatf("rnd%0d_full", c), 32'(full), 32'(sz == DEPTH));
      check($sformatf("rnd%0d_empty", c), 32'(empty), 32'(sz == 0));
`ifdef AXIS_PKT_COUNT_EN
      check($sformatf("rnd%0d_pkt_count", c), 32'(pkt_count), 32'(npk));
`endif
      if (exp_vo && read) void'(model_q.pop_front());
      if (valid && exp_ready) model_q.push_back({last, data});
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
